// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI responder.
//   state_t    : receiver state encoding (ARMWAIT, IDLE, SHIFT)
//   FRAME_BITS : width of the packed frame image (15 bytes)
//   BYTE_W     : bits per SPI byte
package oled_pkg;

    localparam int BYTE_W     = 8;
    localparam int FRAME_BITS = 120;

    typedef enum logic [1:0] {
        ARMWAIT,
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/oled_spi_rx_if.sv
// Bundle of SPI pins and receiver outputs for oled_spi_rx.
//   master : drives cs/sclk/mosi/d_c, observes byte and frame results
//   slave  : the receiver side (oled_spi_rx)
interface oled_spi_rx_if;
    import oled_pkg::*;

    logic                  cs;
    logic                  sclk;
    logic                  mosi;
    logic                  d_c;
    logic                  byte_valid;
    logic [BYTE_W-1:0]     byte_data;
    logic                  byte_dc;
    logic                  frame_done;
    logic [FRAME_BITS-1:0] frame_bytes;
    logic [3:0]            frame_count;
    logic                  frame_dc;
    logic                  frame_mixed;
    logic                  frame_err;
    logic                  frame_ovf;

    modport master (
        output cs, sclk, mosi, d_c,
        input  byte_valid, byte_data, byte_dc, frame_done, frame_bytes,
               frame_count, frame_dc, frame_mixed, frame_err, frame_ovf
    );

    modport slave (
        input  cs, sclk, mosi, d_c,
        output byte_valid, byte_data, byte_dc, frame_done, frame_bytes,
               frame_count, frame_dc, frame_mixed, frame_err, frame_ovf
    );

endinterface

// File: rtl/oled_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized level
//   rise     : q is 1 and was 0 on the previous cycle
//   fall     : q is 0 and was 1 on the previous cycle
module oled_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] pipe;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
            prev <= 1'b0;
        end else begin
            pipe <= {pipe[SYNC_STAGES-2:0], d};
            prev <= pipe[SYNC_STAGES-1];
        end
    end

    assign q    = pipe[SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/oled_spi_rx.sv
// SPI responder for the OLED command/data link. Rebuilds MSB-first bytes,
// tags each with d_c, and publishes the whole chip-select frame on cs rise.
//   clk, rst : system clock (>= 4x sclk), synchronous active-high reset
//   bus      : oled_spi_rx_if.slave -- cs/sclk/mosi/d_c in; byte_valid,
//              byte_data, byte_dc, frame_done, frame_bytes, frame_count,
//              frame_dc, frame_mixed, frame_err, frame_ovf out
module oled_spi_rx
    import oled_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_BYTES   = 15
) (
    input  logic           clk,
    input  logic           rst,
    oled_spi_rx_if.slave   bus
);

    logic cs_s, cs_rise, cs_fall;
    logic sclk_rise, sclk_level_unused, sclk_fall_unused;

    oled_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .rst(rst), .d(bus.cs),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    oled_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .rst(rst), .d(bus.sclk),
        .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    // Same depth as the sclk path so mosi/d_c stay aligned with sclk_rise.
    logic [SYNC_STAGES-1:0] mosi_pipe, dc_pipe;
    logic                   mosi_s, d_c_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_pipe <= '0;
            dc_pipe   <= '0;
        end else begin
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], bus.mosi};
            dc_pipe   <= {dc_pipe[SYNC_STAGES-2:0], bus.d_c};
        end
    end

    assign mosi_s = mosi_pipe[SYNC_STAGES-1];
    assign d_c_s  = dc_pipe[SYNC_STAGES-1];

    state_t                state;
    logic [2:0]            bit_cnt;
    logic [BYTE_W-1:0]     shift_reg;
    logic [3:0]            idx;
    logic [FRAME_BITS-1:0] frame_buf;
    logic                  have_byte, first_dc, last_dc, mixed, ovf;

    logic                  byte_valid_q, byte_dc_q, frame_done_q;
    logic [BYTE_W-1:0]     byte_data_q;
    logic [FRAME_BITS-1:0] frame_bytes_q;
    logic [3:0]            frame_count_q;
    logic                  frame_dc_q, frame_mixed_q, frame_err_q, frame_ovf_q;

    // Next-frame view including a byte completing this cycle, so a byte that
    // finishes together with cs rise lands in the same published frame.
    logic                  shifting, byte_done, store;
    logic [BYTE_W-1:0]     new_byte;
    logic [2:0]            bit_cnt_nxt;
    logic [3:0]            idx_nxt;
    logic [FRAME_BITS-1:0] buf_nxt;
    logic                  first_dc_nxt, mixed_nxt, ovf_nxt;

    always_comb begin
        // In SHIFT, cs_s can only be high on the cs_rise cycle, so gating on
        // the state alone rejects sclk activity while cs is deasserted.
        shifting     = (state == SHIFT) && sclk_rise;
        // 3-bit counter wraps 7->0 on the 8th edge: "reach 8 then clear".
        byte_done    = shifting && (bit_cnt == 3'd7);
        new_byte     = {shift_reg[BYTE_W-2:0], mosi_s};
        store        = byte_done && (32'(idx) < MAX_BYTES);
        bit_cnt_nxt  = shifting ? bit_cnt + 3'd1 : bit_cnt;
        idx_nxt      = store ? idx + 4'd1 : idx;
        ovf_nxt      = ovf | (byte_done && !store);
        first_dc_nxt = (byte_done && !have_byte) ? d_c_s : first_dc;
        mixed_nxt    = mixed | (byte_done && have_byte && (d_c_s != last_dc));
        buf_nxt      = frame_buf;
        for (int unsigned k = 0; k < MAX_BYTES; k++) begin
            if (store && (32'(idx) == k))
                buf_nxt[FRAME_BITS-1-BYTE_W*k -: BYTE_W] = new_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARMWAIT;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            idx           <= '0;
            frame_buf     <= '0;
            have_byte     <= 1'b0;
            first_dc      <= 1'b0;
            last_dc       <= 1'b0;
            mixed         <= 1'b0;
            ovf           <= 1'b0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= '0;
            byte_dc_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_bytes_q <= '0;
            frame_count_q <= '0;
            frame_dc_q    <= 1'b0;
            frame_mixed_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_ovf_q   <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state)
                ARMWAIT: begin
                    if (cs_s) state <= IDLE;
                end
                IDLE: begin
                    if (cs_fall) begin
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        idx       <= '0;
                        frame_buf <= '0;
                        have_byte <= 1'b0;
                        first_dc  <= 1'b0;
                        last_dc   <= 1'b0;
                        mixed     <= 1'b0;
                        ovf       <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bit_cnt   <= bit_cnt_nxt;
                    idx       <= idx_nxt;
                    frame_buf <= buf_nxt;
                    first_dc  <= first_dc_nxt;
                    mixed     <= mixed_nxt;
                    ovf       <= ovf_nxt;
                    if (shifting) shift_reg <= new_byte;
                    if (byte_done) begin
                        have_byte    <= 1'b1;
                        last_dc      <= d_c_s;
                        byte_valid_q <= 1'b1;
                        byte_data_q  <= new_byte;
                        byte_dc_q    <= d_c_s;
                    end
                    if (cs_rise) begin
                        state         <= IDLE;
                        frame_done_q  <= 1'b1;
                        frame_bytes_q <= buf_nxt;
                        frame_count_q <= idx_nxt;
                        frame_dc_q    <= first_dc_nxt;
                        frame_mixed_q <= mixed_nxt;
                        frame_err_q   <= (bit_cnt_nxt != 3'd0);
                        frame_ovf_q   <= ovf_nxt;
                    end
                end
                default: state <= ARMWAIT;
            endcase
        end
    end

    assign bus.byte_valid  = byte_valid_q;
    assign bus.byte_data   = byte_data_q;
    assign bus.byte_dc     = byte_dc_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_bytes = frame_bytes_q;
    assign bus.frame_count = frame_count_q;
    assign bus.frame_dc    = frame_dc_q;
    assign bus.frame_mixed = frame_mixed_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.frame_ovf   = frame_ovf_q;

endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
SPI responder for the OLED command/data link. It watches cs, sclk, mosi and d_c, rebuilds bytes MSB-first and tags each byte as command or data. At the end of each chip-select frame it presents the whole frame in the same 120-bit, 15-byte packed format the transmit side uses. It is used as a synthesizable loopback/sniffer for bring-up and as the checker model in the driver's testbench.

Parameters:
SYNC_STAGES, 2, flops per synchronizer on cs/sclk/mosi/d_c; minimum 2.
MAX_BYTES, 15, bytes stored per frame; frame_bytes width is fixed at 120.

Ports:
clk  in  1  system clock; must be at least 4x the sclk frequency.
rst  in  1  synchronous reset, active-high.
cs  in  1  chip select, active-low, asynchronous to clk.
sclk  in  1  SPI clock, asynchronous; idle level is don't-care.
mosi  in  1  serial data.
d_c  in  1  0 = command, 1 = data.
byte_valid  out  1  one-cycle pulse when a byte completes.
byte_data  out  8  completed byte; valid when byte_valid is high.
byte_dc  out  1  d_c sampled with bit 0 (the 8th bit) of the byte.
frame_done  out  1  one-cycle pulse on cs deassertion after an armed frame.
frame_bytes  out  120  byte k of the frame at [119-8k -: 8]; unused bytes are 0.
frame_count  out  4  bytes stored in the frame, 0..15.
frame_dc  out  1  byte_dc of the first byte in the frame.
frame_mixed  out  1  d_c changed between bytes within the frame.
frame_err  out  1  cs rose with 1..7 bits pending; the partial byte is discarded.
frame_ovf  out  1  more than MAX_BYTES bytes were received in the frame.

Behaviour:
- Synchronization and edge detection:
  - cs, sclk, mosi and d_c each pass through SYNC_STAGES flops.
  - sclk_rise = synchronized sclk is 1 and was 0 on the previous cycle. cs_rise and cs_fall are detected the same way.
- State machine:
  - ARMWAIT: entered on reset. Wait until synchronized cs is 1, then go to IDLE. This prevents a mid-frame capture after reset.
  - IDLE: on cs_fall, clear bit_cnt, the byte index, the frame buffer and the flags, then go to SHIFT.
  - SHIFT:
    - On each sclk_rise, shift_reg <= {shift_reg[6:0], mosi_s} and bit_cnt increments.
    - When bit_cnt reaches 8, pulse byte_valid next cycle with byte_data and byte_dc = d_c_s, then set bit_cnt to 0.
    - The completed byte is stored at index idx if idx < MAX_BYTES; otherwise frame_ovf is set and the byte is not stored. Either way byte_valid still pulses.
    - On cs_rise, go to IDLE and pulse frame_done.
- Latency: byte_valid is high exactly SYNC_STAGES+1 clk cycles after the 8th sclk rising edge reaches the pin.
- Frame outputs:
  - frame_bytes, frame_count, frame_dc, frame_mixed, frame_err and frame_ovf update together with the frame_done pulse.
  - They hold their values until the next frame_done.
  - frame_count saturates at 15.
- Simultaneous events: if sclk_rise completing a byte and cs_rise occur in the same cycle, the byte completes first and is included in the same frame_done. byte_valid and frame_done pulse in the same cycle.
- Empty frame: cs low then high with no sclk edges gives frame_done with count 0 and all flags 0.
- Glitch: sclk_rise while cs_s is 1 is ignored.
- Reset values: all outputs 0 and state ARMWAIT. Reset mid-frame discards the partial frame and produces no frame_done.

Decomposition:
- oled_pkg holds:
  - the typedef for the state enum {ARMWAIT, IDLE, SHIFT};
  - the constant FRAME_BITS = 120;
  - the localparam BYTE_W = 8.
- One natural sub-module: oled_sync_edge (SYNC_STAGES synchronizer plus rise/fall detect), instantiated for cs and sclk. mosi and d_c use the plain synchronizer path.

Test Plan:
1. Reset held with cs low, released, then 8 sclk edges -> no byte_valid. After cs goes high, a frame {0xAF} -> frame_done, frame_count = 1, frame_bytes[119:112] = 0xAF, frame_dc = 0.
2. cs low with d_c = 0, send 0x15 0x00 0x5F -> three byte_valid pulses (0x15, 0x00, 0x5F), each SYNC_STAGES+1 cycles after its 8th edge. frame_count = 3, frame_bytes[119:96] = 0x15005F, rest 0.
3. Frame of 0xA0 (d_c = 0) then 0xFFFF (d_c = 1) -> frame_dc = 0, frame_mixed = 1, per-byte byte_dc = 0, 1, 1.
4. 17 bytes 0x01..0x11 in one frame -> 17 byte_valid pulses, frame_count = 15, frame_bytes ends in 0x0F, frame_ovf = 1.
5. 0x3C followed by 5 extra bits, then cs high -> one byte_valid (0x3C), frame_err = 1, frame_count = 1.
6. cs rise in the same synchronized cycle as the 8th sclk rise of 0x81 -> byte_valid and frame_done in the same cycle, frame_count = 1, frame_err = 0.
